// File: rtl/pp_loop_event_recorder_if.sv
// Profiler handshake bundle: kernel/loop strobes in, event stream and status out.
// The recorder attaches as slave; the kernel/consumer side is master.
interface pp_loop_event_recorder_if #(
  parameter int TS_W   = 32,
  parameter int ITER_W = 16,
  parameter int DROP_W = 16
);
  logic              ap_start;
  logic              ap_done;
  logic              iter_start;
  logic              iter_end;
  logic              evt_valid;
  logic              evt_ready;
  logic [3:0]        evt_flags;
  logic [TS_W-1:0]   evt_ts;
  logic [ITER_W-1:0] evt_start_idx;
  logic [ITER_W-1:0] evt_end_idx;
  logic [ITER_W-1:0] in_flight;
  logic [ITER_W-1:0] max_in_flight;
  logic [DROP_W-1:0] drop_count;
  logic              err_sticky;
  logic [1:0]        state;
  logic              flushed;

  modport master (
    output ap_start, ap_done, iter_start, iter_end, evt_ready,
    input  evt_valid, evt_flags, evt_ts, evt_start_idx, evt_end_idx,
    input  in_flight, max_in_flight, drop_count, err_sticky, state, flushed
  );

  modport slave (
    input  ap_start, ap_done, iter_start, iter_end, evt_ready,
    output evt_valid, evt_flags, evt_ts, evt_start_idx, evt_end_idx,
    output in_flight, max_in_flight, drop_count, err_sticky, state, flushed
  );
endinterface

// File: rtl/pp_loop_event_recorder.sv
// Timestamped event recorder for an HLS kernel's start/done and loop iteration strobes,
// buffered in a first-word-fall-through FIFO for a valid/ready consumer.
//
// state   | meaning
// S_IDLE  | waiting for ap_start; iteration strobes here are protocol errors
// S_RUN   | kernel active; strobes sampled, ap_done ends the run
// S_FLUSH | waiting for the consumer to drain the FIFO, then pulse flushed
module pp_loop_event_recorder #(
  parameter int TS_W       = 32,
  parameter int ITER_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16
) (
  input logic                    clock,
  input logic                    reset,
  pp_loop_event_recorder_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [TS_W-1:0]   TS_ONE   = 1;
  localparam logic [ITER_W-1:0] ITER_ONE = 1;
  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        flags;
    logic [TS_W-1:0]   ts;
    logic [ITER_W-1:0] sidx;
    logic [ITER_W-1:0] eidx;
  } rec_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TS_W-1:0]   r_ts;
  logic [ITER_W-1:0] r_sidx;
  logic [ITER_W-1:0] r_eidx;
  logic [ITER_W-1:0] r_in_flight;
  logic [ITER_W-1:0] r_max;
  logic [DROP_W-1:0] r_drop;
  logic              r_err;
  logic              r_flushed;

  rec_t              r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;

  logic              w_mod_start;
  logic              w_mod_done;
  logic              w_sample;
  logic              w_st;
  logic              w_en;
  logic              w_push;
  logic              w_pop;
  logic              w_wr_en;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;
  logic              w_flush_done;
  logic              w_err;
  logic [ITER_W-1:0] w_sidx_base;
  logic [ITER_W-1:0] w_eidx_base;
  logic [ITER_W-1:0] w_if_base;
  logic [ITER_W-1:0] w_max_base;
  logic [ITER_W-1:0] w_if_nxt;
  logic [ITER_W-1:0] w_max_nxt;
  rec_t              w_rec;
  rec_t              w_head;

  // Event decode; the mod_start cycle also samples strobes against cleared counters.
  assign w_mod_start = (r_state == S_IDLE) && bus.ap_start;
  assign w_mod_done  = (r_state == S_RUN) && bus.ap_done;
  assign w_sample    = (r_state == S_RUN) || w_mod_start;
  assign w_st        = bus.iter_start && w_sample;
  assign w_en        = bus.iter_end && w_sample;

  assign w_sidx_base = w_mod_start ? '0 : r_sidx;
  assign w_eidx_base = w_mod_start ? '0 : r_eidx;
  assign w_if_base   = w_mod_start ? '0 : r_in_flight;
  assign w_max_base  = w_mod_start ? '0 : r_max;

  assign w_rec.flags = {w_mod_done, w_en, w_st, w_mod_start};
  assign w_rec.ts    = r_ts;
  assign w_rec.sidx  = w_sidx_base;
  assign w_rec.eidx  = w_eidx_base;
  assign w_push      = |w_rec.flags;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  assign w_flush_done = (r_state == S_FLUSH) && w_empty && !w_push;

  always_comb begin
    w_if_nxt = w_if_base;
    w_err    = 1'b0;
    if (w_st && !w_en) begin
      w_if_nxt = w_if_base + ITER_ONE;
    end else if (w_en && !w_st) begin
      if (w_if_base == '0) w_err = 1'b1;
      else                 w_if_nxt = w_if_base - ITER_ONE;
    end
    if ((bus.iter_start || bus.iter_end) && !w_sample) w_err = 1'b1;
    w_max_nxt = (w_if_nxt > w_max_base) ? w_if_nxt : w_max_base;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_mod_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_mod_done) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_flush_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ts        <= '0;
      r_sidx      <= '0;
      r_eidx      <= '0;
      r_in_flight <= '0;
      r_max       <= '0;
      r_drop      <= '0;
      r_err       <= 1'b0;
      r_flushed   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ts        <= r_ts + TS_ONE;
      r_sidx      <= w_st ? w_sidx_base + ITER_ONE : w_sidx_base;
      r_eidx      <= w_en ? w_eidx_base + ITER_ONE : w_eidx_base;
      r_in_flight <= w_if_nxt;
      r_max       <= w_max_nxt;
      r_flushed   <= w_flush_done;
      if (w_err) r_err <= 1'b1;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  assign bus.evt_valid     = !w_empty;
  assign bus.evt_flags     = w_head.flags;
  assign bus.evt_ts        = w_head.ts;
  assign bus.evt_start_idx = w_head.sidx;
  assign bus.evt_end_idx   = w_head.eidx;
  assign bus.in_flight     = r_in_flight;
  assign bus.max_in_flight = r_max;
  assign bus.drop_count    = r_drop;
  assign bus.err_sticky    = r_err;
  assign bus.state         = r_state;
  assign bus.flushed       = r_flushed;

endmodule

// File: doc/pp_loop_event_recorder.md
Name: pp_loop_event_recorder

Overview:
- Synthesizable on-chip profiler that sits directly upstream of the CSV dump path for a pipelined HLS kernel.
- Samples the kernel's ap_start/ap_done handshake and the qualified iteration-start/iteration-end strobes of one pipelined loop.
- Packs each active cycle into a timestamped event record and buffers it in a FWFT FIFO, drained by a valid/ready consumer.
- Also tracks iterations in flight and how deep the pipeline gets.

Parameters:
- TS_W, 32, timestamp width; free-running cycle counter, wraps.
- ITER_W, 16, iteration index / in-flight counter width.
- FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.
- DROP_W, 16, drop counter width; saturating.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ap_start  in  1  kernel start (level, held until accepted)
- ap_done  in  1  kernel done pulse
- iter_start  in  1  qualified iteration start strobe (enable & ~block)
- iter_end  in  1  qualified iteration end strobe
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_flags  out  4  {mod_done, iter_end, iter_start, mod_start}
- evt_ts  out  TS_W  cycle timestamp of the event
- evt_start_idx  out  ITER_W  index of iteration starting (valid when flag set)
- evt_end_idx  out  ITER_W  index of iteration ending (valid when flag set)
- in_flight  out  ITER_W  current started-minus-ended count
- max_in_flight  out  ITER_W  peak in_flight since last mod_start
- drop_count  out  DROP_W  records lost to full FIFO (saturating)
- err_sticky  out  1  protocol error seen
- state  out  2  0=IDLE, 1=RUN, 2=FLUSH
- flushed  out  1  one-cycle pulse when FLUSH completes

Behaviour:
- Reset (async assert, sync release): state=IDLE, ts=0, FIFO empty, evt_valid=0, all counters/indices 0, err_sticky=0, flushed=0.
- Reset mid-operation discards all buffered records.
- ts increments every cycle out of reset and wraps 2^TS_W-1 -> 0.
- FSM:
  - IDLE: ap_start=1 -> record with mod_start, clear start_idx/end_idx/in_flight/max_in_flight, go RUN.
  - RUN: ap_start ignored. ap_done=1 -> record includes mod_done, go FLUSH.
  - FLUSH: when FIFO empty and no push this cycle, pulse flushed, go IDLE. ap_start in FLUSH is not sampled; it is held by protocol and taken in IDLE.
- Iteration strobes:
  - Sampled only in RUN. Any strobe in IDLE or FLUSH is ignored and sets err_sticky.
  - In the mod_start cycle the strobes are also sampled, after the counters clear.
- Record rule: at most one record per cycle. A record is formed when any flag is set; all simultaneous events merge into one record.
- evt_start_idx/evt_end_idx carry pre-increment values (0-based). start_idx and end_idx increment on their strobe and wrap at 2^ITER_W.
- in_flight:
  - +1 on start only, -1 on end only, unchanged on both.
  - iter_end with in_flight=0 and no iter_start: sets err_sticky, in_flight stays 0.
  - max_in_flight updates to in_flight's next value whenever that value is larger.
- FIFO:
  - First-word fall-through; a record pushed in cycle N is visible on evt_* in cycle N+1 at earliest.
  - Pop when evt_valid & evt_ready.
  - Full and push without pop: record dropped, drop_count +1 (saturates at 2^DROP_W-1).
  - Full with push and pop in the same cycle: push accepted, no drop.
  - Empty: evt_valid=0; evt_* hold last head value (don't-care).
- evt_* stay stable while evt_valid=1 and evt_ready=0.
- drop_count and err_sticky clear only on reset.

Test Plan:
- Reset release, ap_start high at ts=5, evt_ready=1 -> record {flags=0001, ts=5} visible at ts=6; state=RUN at ts=6.
- Loop of 3 iterations at II=1, depth 2:
  - Starts at ts 10,11,12; ends at ts 12,13,14.
  - Required records: ts10 flags 0010 sidx0; ts11 0010 sidx1; ts12 0110 sidx2 eidx0; ts13 0100 eidx1; ts14 0100 eidx2.
  - max_in_flight=2, in_flight=0 after ts14.
- ap_done coincident with last iter_end -> single record flags 1100; FLUSH; flushed pulses one cycle after FIFO drains; state returns IDLE.
- evt_ready=0 with FIFO_DEPTH=8, 10 consecutive start-only cycles -> 8 records buffered, drop_count=2. Then pop one while pushing in the same cycle -> no further drop.
- iter_end in IDLE, and iter_end with in_flight=0 in RUN -> err_sticky=1, in_flight=0, no record in the IDLE case.
- Async reset asserted mid-RUN with 5 records buffered -> evt_valid=0 immediately, state=IDLE, ts restarts at 0 after release.
